// File: rtl/srrc_prac_hb_decim.sv
// srrc_prac_hb_decim: receive-side 11-tap halfband decimate-by-2 filter.
// Input is s1.17 at the 2x rate (qualified by in_clk_en). Every second
// sample (re-aligned by phase_sync) produces one filtered s1.17 output,
// 3 clocks after the edge that shifts that sample in.
// Optional build macro SRRC_HB_DECIM_RND_EN: round-half-up on the
// coefficient products instead of plain truncation (same latency).
//
// Output handshake: out_valid is a single-clock pulse, with no ready
// and no back-pressure. out is valid while out_valid is high and then
// holds until the next pulse.
module srrc_prac_hb_decim #(
  parameter logic signed [17:0] C0 = 18'sd2621,
  parameter logic signed [17:0] C2 = -18'sd11796,
  parameter logic signed [17:0] C4 = 18'sd40632
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_clk_en,
  input  logic               phase_sync,
  input  logic signed [17:0] in,
  output logic signed [17:0] out,
  output logic               out_valid
);

`ifdef SRRC_HB_DECIM_RND_EN
  localparam logic signed [35:0] RND = 36'sd65536;
`else
  localparam logic signed [35:0] RND = 36'sd0;
`endif

  logic signed [17:0] x_q [11];
  logic signed [17:0] x_d [11];
  logic               phase_q, phase_d;
  logic               qual;
  logic               tok0_q, tok0_d;
  logic               tok1_q, tok2_q;
  logic signed [17:0] f0_q, f2_q, f4_q, c1_q;
  logic signed [17:0] f0_d, f2_d, f4_d;
  logic signed [35:0] p0_q, p2_q, p4_q;
  logic signed [35:0] p0_d, p2_d, p4_d;
  logic signed [17:0] c2_q;
  logic signed [17:0] out_q, out_d;
  logic               valid_q;

  // Next-state logic: sample shift/phase on strobes, free-running pipeline.
  always_comb begin
    x_d     = x_q;
    phase_d = phase_q;
    tok0_d  = 1'b0;
    qual    = phase_q | phase_sync;
    if (in_clk_en) begin
      // Input halving keeps the folded pair sums inside 18 bits.
      x_d[0] = in >>> 1;
      for (int i = 1; i < 11; i++) begin
        x_d[i] = x_q[i-1];
      end
      phase_d = ~qual;
      tok0_d  = qual;
    end

    // Folded symmetric pairs; odd-distance taps are zero and skipped.
    f0_d = x_q[0] + x_q[10];
    f2_d = x_q[2] + x_q[8];
    f4_d = x_q[4] + x_q[6];

    p0_d = 36'(f0_q) * 36'(C0);
    p2_d = 36'(f2_q) * 36'(C2);
    p4_d = 36'(f4_q) * 36'(C4);

    // Each term is product bits [34:17]; the center tap (gain 0.5 on the
    // halved input) is c itself. An 18-bit modular sum equals the low
    // 18 bits of the 20-bit sum, so the wrap behaviour is identical.
    out_d = out_q;
    if (tok2_q) begin
      out_d = 18'((p0_q + RND) >>> 17)
            + 18'((p2_q + RND) >>> 17)
            + 18'((p4_q + RND) >>> 17)
            + c2_q;
    end
  end

  // State registers; async reset drops any output still in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 11; i++) begin
        x_q[i] <= '0;
      end
      phase_q <= 1'b0;
      tok0_q  <= 1'b0;
      tok1_q  <= 1'b0;
      tok2_q  <= 1'b0;
      f0_q    <= '0;
      f2_q    <= '0;
      f4_q    <= '0;
      c1_q    <= '0;
      p0_q    <= '0;
      p2_q    <= '0;
      p4_q    <= '0;
      c2_q    <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      x_q     <= x_d;
      phase_q <= phase_d;
      tok0_q  <= tok0_d;
      tok1_q  <= tok0_q;
      tok2_q  <= tok1_q;
      f0_q    <= f0_d;
      f2_q    <= f2_d;
      f4_q    <= f4_d;
      c1_q    <= x_q[5];
      p0_q    <= p0_d;
      p2_q    <= p2_d;
      p4_q    <= p4_d;
      c2_q    <= c1_q;
      out_q   <= out_d;
      valid_q <= tok2_q;
    end
  end

  assign out       = out_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_srrc_prac_hb_decim.sv
// tb_srrc_prac_hb_decim: scoreboard bench for the halfband decimator.
// Expected values (directed constants or a reference model) and expected
// arrival cycles are queued when samples are driven and checked on out_valid.
module tb_srrc_prac_hb_decim;

  localparam longint C0 = 2621;
  localparam longint C2 = -11796;
  localparam longint C4 = 40632;
`ifdef SRRC_HB_DECIM_RND_EN
  localparam longint RND      = 65536;
  localparam int     DC3      = 48497;
  localparam int     DC4      = 96991;
  localparam int     NEG_IMP  = -655;
`else
  localparam longint RND      = 0;
  localparam int     DC3      = 48496;
  localparam int     DC4      = 96990;
  localparam int     NEG_IMP  = -656;
`endif

  // ---------------- clock / reset ----------------
  logic               clk = 1'b0;
  logic               reset_n;
  logic               in_clk_en;
  logic               phase_sync;
  logic signed [17:0] din;
  logic signed [17:0] dout;
  logic               out_valid;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  srrc_prac_hb_decim dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_clk_en  (in_clk_en),
    .phase_sync (phase_sync),
    .in         (din),
    .out        (dout),
    .out_valid  (out_valid)
  );

  // ---------------- scoreboard state ----------------
  logic signed [17:0] exp_q[$];
  int                 cyc_q[$];
  int                 n_cmp = 0;
  int                 n_err = 0;
  int                 hist [11];
  bit                 m_phase;
  bit                 model_push;
  logic signed [17:0] last_exp;
  logic signed [17:0] mon_e;
  int                 mon_c;

  task automatic check_val(input string tag, input longint got, input longint want);
    n_cmp++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  // Reference: straight tap-by-tap halfband sum on the halved history.
  function automatic int model_out();
    longint             s;
    logic signed [17:0] w;
    s = ((longint'(hist[0] + hist[10]) * C0 + RND) >>> 17)
      + ((longint'(hist[2] + hist[8])  * C2 + RND) >>> 17)
      + ((longint'(hist[4] + hist[6])  * C4 + RND) >>> 17)
      + longint'(hist[5]);
    w = 18'(s);
    return int'(w);
  endfunction

  task automatic push_exp(input int v);
    exp_q.push_back(18'(v));
  endtask

  // ---------------- driver tasks (called at posedge + #1) ----------------
  task automatic drive_sample(input int v, input bit sync, input int gap);
    bit qual;
    din        = 18'(v);
    in_clk_en  = 1'b1;
    phase_sync = sync;
    qual = m_phase | sync;
    for (int i = 10; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = v >>> 1;
    m_phase = !qual;
    if (qual) begin
      cyc_q.push_back(cyc + 4);
      if (model_push) push_exp(model_out());
    end
    @(posedge clk); #1;
    in_clk_en  = 1'b0;
    phase_sync = 1'($urandom_range(0, 1));
    din        = 18'($urandom_range(0, 262143));
    repeat (gap) begin
      @(posedge clk); #1;
    end
    phase_sync = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    exp_q.delete();
    cyc_q.delete();
    last_exp = '0;
    for (int i = 0; i < 11; i++) hist[i] = 0;
    m_phase = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic drain(input string tag);
    repeat (8) @(posedge clk);
    #1;
    check_val({tag, "_drain_vals"}, exp_q.size(), 0);
    check_val({tag, "_drain_cycs"}, cyc_q.size(), 0);
  endtask

  // ---------------- monitor (negedge, away from active edge) ----------------
  always @(negedge clk) begin
    if (out_valid) begin
      if (exp_q.size() == 0 || cyc_q.size() == 0) begin
        check_val("unexpected_valid", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        mon_c = cyc_q.pop_front();
        check_val("out", dout, mon_e);
        check_val("latency", cyc, mon_c);
        last_exp = mon_e;
      end
    end else begin
      check_val("out_hold", dout, last_exp);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    reset_n    = 1'b0;
    in_clk_en  = 1'b0;
    phase_sync = 1'b0;
    din        = '0;
    model_push = 1'b0;
    last_exp   = '0;
    @(posedge clk); #1;
    check_val("rst_out", dout, 0);
    check_val("rst_valid", out_valid, 0);
    do_reset();

    // Impulse on a qualifying sample.
    model_push = 1'b0;
    push_exp(655); push_exp(-2949); push_exp(10158); push_exp(10158);
    push_exp(-2949); push_exp(655); push_exp(0);
    drive_sample(65536, 1'b1, 1);
    for (int i = 0; i < 12; i++) drive_sample(0, 1'b0, 1);
    drain("imp_q");

    // Impulse on a non-qualifying sample (sync on the preceding one).
    do_reset();
    push_exp(0);
    push_exp(0); push_exp(0); push_exp(32768); push_exp(0); push_exp(0); push_exp(0);
    drive_sample(0, 1'b1, 1);
    drive_sample(65536, 1'b0, 1);
    for (int i = 0; i < 11; i++) drive_sample(0, 1'b0, 1);
    drain("imp_nq");

    // DC 0.5 with a strobe every second clock.
    do_reset();
    model_push = 1'b1;
    drive_sample(65536, 1'b1, 1);
    for (int i = 0; i < 11; i++) drive_sample(65536, 1'b0, 1);
    model_push = 1'b0;
    for (int i = 0; i < 6; i++) push_exp(DC3);
    for (int i = 0; i < 12; i++) drive_sample(65536, 1'b0, 1);
    drain("dc_half");

    // Near full-scale DC with back-to-back strobes.
    do_reset();
    model_push = 1'b1;
    drive_sample(131071, 1'b1, 0);
    for (int i = 0; i < 11; i++) drive_sample(131071, 1'b0, 0);
    model_push = 1'b0;
    for (int i = 0; i < 8; i++) push_exp(DC4);
    for (int i = 0; i < 16; i++) drive_sample(131071, 1'b0, 0);
    drain("dc_full");

    // Negative impulse: truncation vs rounding differ on the first output.
    do_reset();
    model_push = 1'b0;
    push_exp(NEG_IMP);
    drive_sample(-65536, 1'b1, 1);
    model_push = 1'b1;
    for (int i = 0; i < 12; i++) drive_sample(0, 1'b0, 1);
    drain("neg_imp");

    // Random samples, gaps and occasional re-sync.
    do_reset();
    model_push = 1'b1;
    for (int i = 0; i < 150; i++) begin
      drive_sample(int'($urandom_range(0, 262143)) - 131072,
                   1'($urandom_range(0, 15) == 0),
                   int'($urandom_range(0, 2)));
    end
    drain("random");

    // Reset one clock after a qualifying edge drops the pending output.
    do_reset();
    model_push = 1'b1;
    drive_sample(40000, 1'b1, 0);
    @(posedge clk); #1;
    do_reset();
    repeat (6) @(posedge clk);
    #1;
    check_val("mid_rst_out", dout, 0);
    check_val("mid_rst_pending", exp_q.size(), 0);
    drive_sample(20000, 1'b0, 1);
    drive_sample(-30000, 1'b0, 1);
    check_val("post_rst_queued", cyc_q.size(), 1);
    drain("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
